apb_arb2: RTL and testbench

Two-requester APB arbiter that lets two APB masters share one APB slave, for example the UART APB peripheral. Each master port is a standard APB slave-side interface. The single downstream port is an APB master interface. The block sequences the SETUP/ACCESS phases on the shared slave, holds the losing master in wait states, and schedules the masters round-robin so neither starves.

---
 rtl/apb_arb2.sv | 129 ++++++++++++
 tb/tb_apb_arb2.sv | 503 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_arb2.sv
// Two-master APB arbiter sharing one APB slave.
// Round-robin grant, one IDLE cycle between transfers.
module apb_arb2 #(
   parameter int AW = 5,
   parameter int DW = 32
) (
   input  logic          pclk,
   input  logic          presetn,
   input  logic [AW-1:0] m0_paddr,
   input  logic [DW-1:0] m0_pwdata,
   input  logic          m0_psel,
   input  logic          m0_penable,
   input  logic          m0_pwrite,
   output logic [DW-1:0] m0_prdata,
   output logic          m0_pready,
   output logic          m0_pslverr,
   input  logic [AW-1:0] m1_paddr,
   input  logic [DW-1:0] m1_pwdata,
   input  logic          m1_psel,
   input  logic          m1_penable,
   input  logic          m1_pwrite,
   output logic [DW-1:0] m1_prdata,
   output logic          m1_pready,
   output logic          m1_pslverr,
   output logic [AW-1:0] s_paddr,
   output logic [DW-1:0] s_pwdata,
   output logic          s_psel,
   output logic          s_penable,
   output logic          s_pwrite,
   input  logic [DW-1:0] s_prdata,
   input  logic          s_pready,
   input  logic          s_pslverr,
   output logic [1:0]    gnt
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SETUP  = 2'b01,
      ACCESS = 2'b10
   } state_t;

   state_t     state;
   logic       ptr;
   logic [1:0] req;
   logic [1:0] pick;
   logic       acc;
   logic       unused_pen;

   assign req = {m1_psel, m0_psel};
   assign acc = (state == ACCESS);

   // penable plays no part in arbitration
   assign unused_pen = m0_penable ^ m1_penable;

   // ptr=1 means m1 wins a tie (m0 was served last)
   always_comb begin
      pick = 2'b00;
      case (req)
         2'b01:   pick = 2'b01;
         2'b10:   pick = 2'b10;
         2'b11:   pick = ptr ? 2'b10 : 2'b01;
         default: pick = 2'b00;
      endcase
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state <= IDLE;
         gnt   <= 2'b00;
         ptr   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick != 2'b00) begin
                  gnt   <= pick;
                  state <= SETUP;
               end
            end
            SETUP: state <= ACCESS;
            ACCESS: begin
               if (s_pready) begin
                  state <= IDLE;
                  gnt   <= 2'b00;
                  ptr   <= gnt[0];
               end
            end
            default: begin
               state <= IDLE;
               gnt   <= 2'b00;
            end
         endcase
      end
   end

   assign s_psel    = (state == SETUP) | acc;
   assign s_penable = acc;

   // gnt is zero in IDLE, so the bus idles at zero
   always_comb begin
      s_paddr  = '0;
      s_pwdata = '0;
      s_pwrite = 1'b0;
      unique case (1'b1)
         gnt[0]: begin
            s_paddr  = m0_paddr;
            s_pwdata = m0_pwdata;
            s_pwrite = m0_pwrite;
         end
         gnt[1]: begin
            s_paddr  = m1_paddr;
            s_pwdata = m1_pwdata;
            s_pwrite = m1_pwrite;
         end
         default: begin
            s_paddr  = '0;
            s_pwdata = '0;
            s_pwrite = 1'b0;
         end
      endcase
   end

   assign m0_pready  = acc & gnt[0] & s_pready;
   assign m1_pready  = acc & gnt[1] & s_pready;
   assign m0_prdata  = (acc & gnt[0]) ? s_prdata : '0;
   assign m1_prdata  = (acc & gnt[1]) ? s_prdata : '0;
   assign m0_pslverr = acc & gnt[0] & s_pslverr;
   assign m1_pslverr = acc & gnt[1] & s_pslverr;

endmodule

// File: tb/tb_apb_arb2.sv
// Bench for apb_arb2: directed scenarios plus random
// traffic against a transaction-timing reference model.
module tb_apb_arb2;
   localparam int AW = 5;
   localparam int DW = 32;

   logic          pclk = 1'b0;
   logic          presetn = 1'b0;
   logic [AW-1:0] paddr[2];
   logic [DW-1:0] pwdata[2];
   logic          psel[2];
   logic          penable[2];
   logic          pwrite[2];
   logic [DW-1:0] prdata[2];
   logic          pready[2];
   logic          pslverr[2];
   logic [AW-1:0] s_paddr;
   logic [DW-1:0] s_pwdata;
   logic          s_psel;
   logic          s_penable;
   logic          s_pwrite;
   logic [DW-1:0] s_prdata;
   logic          s_pready;
   logic          s_pslverr;
   logic [1:0]    gnt;

   int n_cmp = 0;
   int n_err = 0;

   apb_arb2 #(.AW(AW), .DW(DW)) dut (
      .pclk       (pclk),
      .presetn    (presetn),
      .m0_paddr   (paddr[0]),
      .m0_pwdata  (pwdata[0]),
      .m0_psel    (psel[0]),
      .m0_penable (penable[0]),
      .m0_pwrite  (pwrite[0]),
      .m0_prdata  (prdata[0]),
      .m0_pready  (pready[0]),
      .m0_pslverr (pslverr[0]),
      .m1_paddr   (paddr[1]),
      .m1_pwdata  (pwdata[1]),
      .m1_psel    (psel[1]),
      .m1_penable (penable[1]),
      .m1_pwrite  (pwrite[1]),
      .m1_prdata  (prdata[1]),
      .m1_pready  (pready[1]),
      .m1_pslverr (pslverr[1]),
      .s_paddr    (s_paddr),
      .s_pwdata   (s_pwdata),
      .s_psel     (s_psel),
      .s_penable  (s_penable),
      .s_pwrite   (s_pwrite),
      .s_prdata   (s_prdata),
      .s_pready   (s_pready),
      .s_pslverr  (s_pslverr),
      .gnt        (gnt)
   );

   always #5 pclk = ~pclk;

   task automatic tick;
      @(posedge pclk);
      #1;
   endtask

   task automatic clear_masters;
      for (int m = 0; m < 2; m++) begin
         psel[m]    = 1'b0;
         penable[m] = 1'b0;
         paddr[m]   = '0;
         pwdata[m]  = '0;
         pwrite[m]  = 1'b0;
      end
   endtask

   task automatic reset_dut;
      presetn = 1'b0;
      clear_masters();
      s_pready  = 1'b0;
      s_prdata  = '0;
      s_pslverr = 1'b0;
      repeat (2) @(posedge pclk);
      @(negedge pclk);
      presetn = 1'b1;
      tick();
   endtask

   // lone transfer on a zero-wait slave; reports latency and grant
   task automatic run_one(input int m, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic w,
                          output int lat, output logic [1:0] g);
      lat = -1;
      g = 2'b00;
      s_pready = 1'b1;
      psel[m] = 1'b1;
      penable[m] = 1'b0;
      paddr[m] = a;
      pwdata[m] = d;
      pwrite[m] = w;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (s_psel && !s_penable) g = gnt;
         penable[m] = 1'b1;
         if (pready[m]) begin
            lat = c;
            break;
         end
      end
      tick();
      psel[m] = 1'b0;
      penable[m] = 1'b0;
   endtask

   task automatic test_reset;
      presetn = 1'b0;
      psel[0] = 1'b1;
      psel[1] = 1'b1;
      penable[0] = 1'b1;
      paddr[1] = 5'h1F;
      pwdata[0] = 32'hFFFF_FFFF;
      s_prdata = 32'hFFFF_FFFF;
      s_pready = 1'b1;
      s_pslverr = 1'b1;
      repeat (3) tick();
      n_cmp++;
      if ({s_psel, s_penable, s_pwrite, s_paddr, s_pwdata,
           prdata[0], prdata[1], pready[0], pready[1],
           pslverr[0], pslverr[1], gnt} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got psel=%b pen=%b rdy=%b%b gnt=%b addr=%h rd0=%h, need all 0",
                  s_psel, s_penable, pready[0], pready[1], gnt, s_paddr, prdata[0]);
      end
      reset_dut();
   endtask

   task automatic test_single_write;
      s_pready = 1'b1;
      psel[0] = 1'b1;
      penable[0] = 1'b0;
      paddr[0] = 5'h04;
      pwdata[0] = 32'hA5;
      pwrite[0] = 1'b1;
      #1;
      n_cmp++;
      if ({s_psel, gnt} !== 3'b000) begin
         n_err++;
         $display("FAIL wr_cycleT: got psel=%b gnt=%b, need 0 00", s_psel, gnt);
      end
      tick();
      n_cmp++;
      if ({s_psel, s_penable, pready[0], pready[1], gnt} !== 6'b1000_01) begin
         n_err++;
         $display("FAIL wr_setup: got %b, need 100001",
                  {s_psel, s_penable, pready[0], pready[1], gnt});
      end
      n_cmp++;
      if ({s_paddr, s_pwdata, s_pwrite} !== {5'h04, 32'hA5, 1'b1}) begin
         n_err++;
         $display("FAIL wr_bus: got a=%h d=%h w=%b, need 04 a5 1",
                  s_paddr, s_pwdata, s_pwrite);
      end
      penable[0] = 1'b1;
      tick();
      n_cmp++;
      if ({s_psel, s_penable, pready[0], pready[1], gnt} !== 6'b1110_01) begin
         n_err++;
         $display("FAIL wr_access: got %b, need 111001",
                  {s_psel, s_penable, pready[0], pready[1], gnt});
      end
      tick();
      psel[0] = 1'b0;
      penable[0] = 1'b0;
      #1;
      n_cmp++;
      if ({s_psel, s_penable, pready[0], pready[1], gnt, s_paddr} !== '0) begin
         n_err++;
         $display("FAIL wr_done: got psel=%b pen=%b rdy=%b%b gnt=%b, need 0",
                  s_psel, s_penable, pready[0], pready[1], gnt);
      end
   endtask

   task automatic test_contention;
      reset_dut();
      s_pready = 1'b1;
      s_prdata = 32'h1111_1111;
      psel[0] = 1'b1;
      paddr[0] = 5'h08;
      pwrite[0] = 1'b0;
      psel[1] = 1'b1;
      paddr[1] = 5'h10;
      pwdata[1] = 32'h1234_5678;
      pwrite[1] = 1'b1;
      tick();
      n_cmp++;
      if ({gnt, s_paddr, s_pwrite} !== {2'b01, 5'h08, 1'b0}) begin
         n_err++;
         $display("FAIL con_first: got gnt=%b a=%h w=%b, need 01 08 0",
                  gnt, s_paddr, s_pwrite);
      end
      penable[0] = 1'b1;
      penable[1] = 1'b1;
      tick();
      n_cmp++;
      if ({pready[0], pready[1], prdata[0], prdata[1]} !==
          {2'b10, 32'h1111_1111, 32'h0}) begin
         n_err++;
         $display("FAIL con_m0_done: got rdy=%b%b rd0=%h rd1=%h, need 10 11111111 0",
                  pready[0], pready[1], prdata[0], prdata[1]);
      end
      tick();
      psel[0] = 1'b0;
      penable[0] = 1'b0;
      tick();
      n_cmp++;
      if ({gnt, s_psel, s_penable, s_paddr, s_pwdata, s_pwrite} !==
          {2'b10, 2'b10, 5'h10, 32'h1234_5678, 1'b1}) begin
         n_err++;
         $display("FAIL con_m1_setup: got gnt=%b psel=%b pen=%b a=%h d=%h, need 10 1 0 10 12345678",
                  gnt, s_psel, s_penable, s_paddr, s_pwdata);
      end
      tick();
      n_cmp++;
      if ({pready[0], pready[1]} !== 2'b01) begin
         n_err++;
         $display("FAIL con_m1_done: got rdy=%b%b at T+5, need 01", pready[0], pready[1]);
      end
      tick();
      psel[1] = 1'b0;
      penable[1] = 1'b0;
   endtask

   task automatic test_back_to_back;
      int         left[2];
      logic       saw[2];
      logic [1:0] glog[$];
      logic [1:0] exp_g;
      left[0] = 4;
      left[1] = 4;
      s_pready = 1'b1;
      for (int m = 0; m < 2; m++) begin
         psel[m] = 1'b1;
         penable[m] = 1'b0;
         paddr[m] = AW'($urandom);
      end
      for (int c = 0; c < 80 && (left[0] > 0 || left[1] > 0); c++) begin
         #1;
         if (s_psel && !s_penable) glog.push_back(gnt);
         saw = pready;
         tick();
         for (int m = 0; m < 2; m++) begin
            if (psel[m]) begin
               if (!penable[m]) penable[m] = 1'b1;
               else if (saw[m]) begin
                  left[m]--;
                  penable[m] = 1'b0;
                  paddr[m] = AW'($urandom);
                  if (left[m] == 0) psel[m] = 1'b0;
               end
            end
         end
      end
      n_cmp++;
      if (left[0] != 0 || left[1] != 0 || glog.size() != 8) begin
         n_err++;
         $display("FAIL b2b_count: got left=%0d/%0d grants=%0d, need 0/0 8",
                  left[0], left[1], glog.size());
      end
      for (int i = 0; i < 8; i++) begin
         exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
         n_cmp++;
         if (i >= glog.size() || glog[i] !== exp_g) begin
            n_err++;
            $display("FAIL b2b_order[%0d]: got %b, need %b",
                     i, (i < glog.size()) ? glog[i] : 2'bxx, exp_g);
         end
      end
   endtask

   task automatic test_wait_err;
      s_pready = 1'b0;
      s_prdata = '0;
      psel[1] = 1'b1;
      paddr[1] = 5'h1C;
      pwrite[1] = 1'b0;
      tick();
      penable[1] = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_cmp++;
         if ({s_penable, gnt, pready[1]} !== 4'b1100) begin
            n_err++;
            $display("FAIL wt_stall[%0d]: got pen=%b gnt=%b rdy1=%b, need 1 10 0",
                     c, s_penable, gnt, pready[1]);
         end
      end
      tick();
      s_pready = 1'b1;
      s_prdata = 32'hDEAD_BEEF;
      s_pslverr = 1'b1;
      #1;
      n_cmp++;
      if ({pready[1], prdata[1], pslverr[1]} !== {1'b1, 32'hDEAD_BEEF, 1'b1}) begin
         n_err++;
         $display("FAIL wt_m1_resp: got rdy=%b rd=%h err=%b, need 1 deadbeef 1",
                  pready[1], prdata[1], pslverr[1]);
      end
      n_cmp++;
      if ({pready[0], prdata[0], pslverr[0]} !== '0) begin
         n_err++;
         $display("FAIL wt_m0_quiet: got rdy=%b rd=%h err=%b, need 0",
                  pready[0], prdata[0], pslverr[0]);
      end
      tick();
      psel[1] = 1'b0;
      penable[1] = 1'b0;
      #1;
      n_cmp++;
      if ({prdata[1], pslverr[1], pready[1]} !== '0) begin
         n_err++;
         $display("FAIL wt_idle_gate: got rd=%h err=%b rdy=%b, need 0",
                  prdata[1], pslverr[1], pready[1]);
      end
      s_prdata = '0;
      s_pslverr = 1'b0;
   endtask

   task automatic test_lone_m1;
      int         lat;
      logic [1:0] g;
      run_one(1, 5'h03, 32'h77, 1'b1, lat, g);
      run_one(1, 5'h05, 32'h88, 1'b0, lat, g);
      n_cmp++;
      if (lat != 2 || g !== 2'b10) begin
         n_err++;
         $display("FAIL lone_m1: got lat=%0d gnt=%b, need 2 10", lat, g);
      end
      psel[0] = 1'b1;
      psel[1] = 1'b1;
      tick();
      n_cmp++;
      if (gnt !== 2'b01) begin
         n_err++;
         $display("FAIL lone_ptr_m0: got gnt=%b, need 01", gnt);
      end
      reset_dut();
   endtask

   task automatic test_reset_mid;
      int         lat;
      logic [1:0] g;
      run_one(0, 5'h01, 32'h99, 1'b1, lat, g);
      n_cmp++;
      if (lat != 2 || g !== 2'b01) begin
         n_err++;
         $display("FAIL rm_pre: got lat=%0d gnt=%b, need 2 01", lat, g);
      end
      s_pready = 1'b0;
      psel[0] = 1'b1;
      paddr[0] = 5'h0A;
      pwrite[0] = 1'b1;
      tick();
      penable[0] = 1'b1;
      tick();
      tick();
      s_pready = 1'b1;
      #1;
      n_cmp++;
      if ({s_psel, s_penable, pready[0], gnt} !== 5'b111_01) begin
         n_err++;
         $display("FAIL rm_lone_access: got psel=%b pen=%b rdy=%b gnt=%b, need 1 1 1 01",
                  s_psel, s_penable, pready[0], gnt);
      end
      presetn = 1'b0;
      #1;
      n_cmp++;
      if ({s_psel, s_penable, pready[0], pready[1], gnt, s_paddr} !== '0) begin
         n_err++;
         $display("FAIL rm_async: got psel=%b pen=%b rdy=%b%b gnt=%b, need 0",
                  s_psel, s_penable, pready[0], pready[1], gnt);
      end
      penable[0] = 1'b0;
      psel[1] = 1'b1;
      @(negedge pclk);
      presetn = 1'b1;
      tick();
      n_cmp++;
      if (gnt !== 2'b01) begin
         n_err++;
         $display("FAIL rm_after: got gnt=%b, need 01", gnt);
      end
      reset_dut();
   endtask

   // reference: a granted transfer shows SETUP one cycle after the
   // arbitration cycle, ACCESS from the next, and ends on slave ready
   task automatic test_random;
      bit            busy;
      int            own, t0, ptr_m;
      int            served[2], seen[2];
      logic          saw[2];
      logic [1:0]    eg;
      logic          epen;
      logic          epr[2], eerr[2];
      logic [DW-1:0] erd[2];
      logic [109:0]  obs, exp_v;
      busy = 0;
      own = 0;
      t0 = 0;
      ptr_m = 0;
      served = '{0, 0};
      seen = '{0, 0};
      saw = '{1'b0, 1'b0};
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int m = 0; m < 2; m++) begin
            if (psel[m] && penable[m] && saw[m]) begin
               penable[m] = 1'b0;
               psel[m] = $urandom_range(1);
            end else if (psel[m]) begin
               penable[m] = 1'b1;
            end else if ($urandom_range(1) == 1) begin
               psel[m] = 1'b1;
            end
            if (psel[m] && !penable[m]) begin
               paddr[m] = AW'($urandom);
               pwdata[m] = $urandom;
               pwrite[m] = 1'($urandom_range(1));
            end
         end
         s_pready = ($urandom_range(2) != 0);
         s_prdata = $urandom;
         s_pslverr = ($urandom_range(3) == 0);
         #1;
         eg = 2'b00;
         epen = 1'b0;
         epr = '{1'b0, 1'b0};
         eerr = '{1'b0, 1'b0};
         erd = '{'0, '0};
         if (busy) begin
            eg = (own == 1) ? 2'b10 : 2'b01;
            epen = (cyc >= t0 + 2);
            epr[own] = epen & s_pready;
            eerr[own] = epen & s_pslverr;
            erd[own] = epen ? s_prdata : '0;
         end
         exp_v = {eg, busy, epen,
                  busy ? paddr[own] : {AW{1'b0}},
                  busy ? pwdata[own] : {DW{1'b0}},
                  busy ? pwrite[own] : 1'b0,
                  epr[0], epr[1], erd[0], erd[1], eerr[0], eerr[1]};
         obs = {gnt, s_psel, s_penable, s_paddr, s_pwdata, s_pwrite,
                pready[0], pready[1], prdata[0], prdata[1],
                pslverr[0], pslverr[1]};
         n_cmp++;
         if (obs !== exp_v) begin
            n_err++;
            $display("FAIL rnd_cycle%0d: got %h, need %h", cyc, obs, exp_v);
         end
         saw = pready;
         for (int m = 0; m < 2; m++) seen[m] += int'(pready[m]);
         if (busy && epen && s_pready) begin
            busy = 0;
            served[own]++;
            ptr_m = 1 - own;
         end else if (!busy && (psel[0] || psel[1])) begin
            busy = 1;
            t0 = cyc;
            own = (psel[0] && psel[1]) ? ptr_m : (psel[1] ? 1 : 0);
         end
         tick();
      end
      n_cmp++;
      if (seen[0] != served[0] || seen[1] != served[1]) begin
         n_err++;
         $display("FAIL rnd_served: got %0d/%0d, need %0d/%0d",
                  seen[0], seen[1], served[0], served[1]);
      end
   endtask

   initial begin
      clear_masters();
      s_pready = 1'b0;
      s_prdata = '0;
      s_pslverr = 1'b0;
      test_reset();
      test_single_write();
      test_contention();
      test_back_to_back();
      test_wait_err();
      test_lone_m1();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, need finish");
      $fatal(1);
   end

endmodule
